// File: rtl/conv_pkg.sv
// Shared definitions for the streaming 2-D convolution engine: FSM encoding,
// width helper, output-size calculation and flat-bus bit-offset helpers.
package conv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StEmit,
    StDone
  } conv_state_e;

  // Ceiling log2 with a floor of one bit so single-valued counters stay legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result = 1;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

  function automatic int unsigned out_size(input int unsigned img_size,
                                           input int unsigned win,
                                           input int unsigned stride);
    return (img_size - win) / stride + 1;
  endfunction

  // Pixel (ch, r, c) within the flattened feature-map bus.
  function automatic int unsigned pix_offset(input int unsigned ch, input int unsigned r,
                                             input int unsigned c, input int unsigned img_size,
                                             input int unsigned elem_w);
    return ((ch * img_size + r) * img_size + c) * elem_w;
  endfunction

  // Tap (ch, r, c) within the flattened kernel bus.
  function automatic int unsigned ker_offset(input int unsigned ch, input int unsigned r,
                                             input int unsigned c, input int unsigned win,
                                             input int unsigned ker_w);
    return ((ch * win + r) * win + c) * ker_w;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered signed multiply-accumulate: unsigned pixel times signed tap,
// accumulated modulo 2^ACC_W, with synchronous clear taking priority over enable.
module conv_mac #(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned KER_W  = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic [ELEM_W-1:0]        pix,
  input  logic signed [KER_W-1:0]  ker,
  output logic [ACC_W-1:0]         acc
);

  localparam int unsigned ProdW = ELEM_W + KER_W + 1;

  logic signed [ProdW-1:0] prod;
  logic [ACC_W-1:0]        acc_q;

  // Pixel is zero-extended so it stays non-negative in the signed product.
  always_comb begin
    prod = ProdW'($signed({1'b0, pix})) * ProdW'(ker);
  end

  // Accumulator register; the product is sign-extended before the wrapping add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + ACC_W'(prod);
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv2d_stream_engine.sv
// Sequential 2-D convolution: one MAC per clock over WIN*WIN*IN_CH taps per output,
// results streamed row-major on a valid/ready port with optional ReLU.
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int unsigned IMG_SIZE = 28,
  parameter int unsigned WIN      = 3,
  parameter int unsigned IN_CH    = 1,
  parameter int unsigned ELEM_W   = 8,
  parameter int unsigned KER_W    = 8,
  parameter int unsigned ACC_W    = 20,
  parameter int unsigned STRIDE   = 1,
  localparam int unsigned OUT_SIZE = out_size(IMG_SIZE, WIN, STRIDE),
  localparam int unsigned POS_W    = clog2(OUT_SIZE)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    relu_en,
  input  logic [IN_CH*IMG_SIZE*IMG_SIZE*ELEM_W-1:0] i_featuremap,
  input  logic [IN_CH*WIN*WIN*KER_W-1:0]          kernel,
  output logic                                    busy,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [ACC_W-1:0]                        out_data,
  output logic [POS_W-1:0]                        out_row,
  output logic [POS_W-1:0]                        out_col,
  output logic                                    done
);

  localparam int unsigned WinW     = clog2(WIN);
  localparam int unsigned ChW      = clog2(IN_CH);
  localparam int unsigned FmW      = IN_CH * IMG_SIZE * IMG_SIZE * ELEM_W;
  localparam int unsigned FmIdxW   = clog2(FmW);
  localparam int unsigned KerVecW  = IN_CH * WIN * WIN * KER_W;
  localparam int unsigned KerIdxW  = clog2(KerVecW);

  conv_state_e state_q, state_d;
  logic [POS_W-1:0] row_q, row_d, col_q, col_d;
  logic [WinW-1:0]  kr_q, kr_d, kc_q, kc_d;
  logic [ChW-1:0]   ch_q, ch_d;
  logic             relu_q, relu_d;

  logic                    mac_clr, mac_en;
  logic [ACC_W-1:0]        acc;
  logic [ELEM_W-1:0]       pix;
  logic signed [KER_W-1:0] ker_tap;
  logic [FmIdxW-1:0]       pix_idx;
  logic [KerIdxW-1:0]      ker_idx;
  int unsigned             pix_row, pix_col;

  logic kc_last, kr_last, tap_last, col_last, pos_last;

  assign kc_last  = (kc_q == WinW'(WIN - 1));
  assign kr_last  = (kr_q == WinW'(WIN - 1));
  assign tap_last = kc_last && kr_last && (ch_q == ChW'(IN_CH - 1));
  assign col_last = (col_q == POS_W'(OUT_SIZE - 1));
  assign pos_last = col_last && (row_q == POS_W'(OUT_SIZE - 1));

  // Current tap address: window origin (row*STRIDE, col*STRIDE) offset by (kr, kc).
  always_comb begin
    pix_row = 32'(row_q) * STRIDE + 32'(kr_q);
    pix_col = 32'(col_q) * STRIDE + 32'(kc_q);
    pix_idx = FmIdxW'(pix_offset(32'(ch_q), pix_row, pix_col, IMG_SIZE, ELEM_W));
    ker_idx = KerIdxW'(ker_offset(32'(ch_q), 32'(kr_q), 32'(kc_q), WIN, KER_W));
    pix     = i_featuremap[pix_idx +: ELEM_W];
    ker_tap = $signed(kernel[ker_idx +: KER_W]);
  end

  conv_mac #(
    .ELEM_W (ELEM_W),
    .KER_W  (KER_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .pix (pix),
    .ker (ker_tap),
    .acc (acc)
  );

  // Next-state logic: FSM, tap counters (kc fastest, then kr, then ch), scan position.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    ch_d    = ch_q;
    relu_d  = relu_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMac;
          row_d   = '0;
          col_d   = '0;
          kr_d    = '0;
          kc_d    = '0;
          ch_d    = '0;
          relu_d  = relu_en;
          mac_clr = 1'b1;
        end
      end
      StMac: begin
        mac_en = 1'b1;
        if (tap_last) begin
          state_d = StEmit;
          kr_d    = '0;
          kc_d    = '0;
          ch_d    = '0;
        end else if (kc_last) begin
          kc_d = '0;
          if (kr_last) begin
            kr_d = '0;
            ch_d = ch_q + 1'b1;
          end else begin
            kr_d = kr_q + 1'b1;
          end
        end else begin
          kc_d = kc_q + 1'b1;
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (pos_last) begin
            state_d = StDone;
          end else begin
            state_d = StMac;
            mac_clr = 1'b1;
            if (col_last) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and counter registers; an asynchronous reset abandons any pass in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      ch_q    <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      ch_q    <= ch_d;
      relu_q  <= relu_d;
    end
  end

  // Outputs are decoded from registered state, so they hold steady under backpressure.
  always_comb begin
    busy      = (state_q == StMac) || (state_q == StEmit);
    out_valid = (state_q == StEmit);
    done      = (state_q == StDone);
    out_row   = row_q;
    out_col   = col_q;
    out_data  = (relu_q && acc[ACC_W-1]) ? '0 : acc;
  end

endmodule
